// File: rtl/parity_frame_ctrl_if.sv
// Signal bundle between the word producer, parity_frame_ctrl and the result consumer.
// The serial strobe lines feed the downstream bit-serial parity checker.
interface parity_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int OW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_clr;
    logic             ser_en;
    logic             ser_x;
    logic             out_valid;
    logic             out_ready;
    logic             parity_out;
    logic [OW-1:0]    ones_cnt;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, ser_clr, ser_en, ser_x, out_valid, parity_out, ones_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, ser_clr, ser_en, ser_x, out_valid, parity_out, ones_cnt, busy
    );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Frames a parallel word into an LSB-first serial strobe stream and reports its
// parity and ones-count over a valid/ready result handshake. All outputs are registered.
module parity_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    parity_frame_ctrl_if.slave io_bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int OW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic          ODD_BIT  = 1'(ODD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic f_parity_fold(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    state_t           r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_shreg,   w_shreg_nxt;
    logic [CW-1:0]    r_cnt,     w_cnt_nxt;
    logic             r_acc,     w_acc_nxt;
    logic [OW-1:0]    r_ones,    w_ones_nxt;
    logic             r_in_ready,  w_in_ready_nxt;
    logic             r_ser_clr,   w_ser_clr_nxt;
    logic             r_ser_en,    w_ser_en_nxt;
    logic             r_ser_x,     w_ser_x_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_parity,    w_parity_nxt;
    logic [OW-1:0]    r_ones_out,  w_ones_out_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             w_acc_fin;
    logic [OW-1:0]    w_ones_fin;

    assign w_acc_fin  = f_parity_fold(r_acc, r_shreg[0]);
    assign w_ones_fin = r_ones + OW'(r_shreg[0]);

    // Next-state and next-output decode; outputs are precomputed so they leave flops.
    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_cnt_nxt       = r_cnt;
        w_acc_nxt       = r_acc;
        w_ones_nxt      = r_ones;
        w_in_ready_nxt  = 1'b0;
        w_ser_clr_nxt   = 1'b0;
        w_ser_en_nxt    = 1'b0;
        w_ser_x_nxt     = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_parity_nxt    = r_parity;
        w_ones_out_nxt  = r_ones_out;
        w_busy_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.in_valid && r_in_ready) begin
                    w_state_nxt   = ST_SHIFT;
                    w_shreg_nxt   = io_bus.in_data;
                    w_cnt_nxt     = {CW{1'b0}};
                    w_acc_nxt     = 1'b0;
                    w_ones_nxt    = {OW{1'b0}};
                    w_ser_clr_nxt = 1'b1;
                    w_ser_en_nxt  = 1'b1;
                    w_ser_x_nxt   = io_bus.in_data[0];
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_in_ready_nxt = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
                w_cnt_nxt   = r_cnt + CW'(1);
                w_acc_nxt   = w_acc_fin;
                w_ones_nxt  = w_ones_fin;
                w_busy_nxt  = 1'b1;
                // The final fold is taken from the live bit so DONE presents it immediately.
                if (r_cnt == LAST_BIT) begin
                    w_state_nxt     = ST_DONE;
                    w_out_valid_nxt = 1'b1;
                    w_parity_nxt    = w_acc_fin ^ ODD_BIT;
                    w_ones_out_nxt  = w_ones_fin;
                end else begin
                    w_ser_en_nxt = 1'b1;
                    w_ser_x_nxt  = r_shreg[1];
                end
            end
            ST_DONE: begin
                if (io_bus.out_ready) begin
                    w_state_nxt    = ST_IDLE;
                    w_in_ready_nxt = 1'b1;
                end else begin
                    w_out_valid_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_in_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_acc       <= 1'b0;
            r_ones      <= {OW{1'b0}};
            r_in_ready  <= 1'b1;
            r_ser_clr   <= 1'b0;
            r_ser_en    <= 1'b0;
            r_ser_x     <= 1'b0;
            r_out_valid <= 1'b0;
            r_parity    <= 1'b0;
            r_ones_out  <= {OW{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_ones      <= w_ones_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_ser_clr   <= w_ser_clr_nxt;
            r_ser_en    <= w_ser_en_nxt;
            r_ser_x     <= w_ser_x_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_parity    <= w_parity_nxt;
            r_ones_out  <= w_ones_out_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign io_bus.in_ready   = r_in_ready;
    assign io_bus.ser_clr    = r_ser_clr;
    assign io_bus.ser_en     = r_ser_en;
    assign io_bus.ser_x      = r_ser_x;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.parity_out = r_parity;
    assign io_bus.ones_cnt   = r_ones_out;
    assign io_bus.busy       = r_busy;
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench for parity_frame_ctrl: an even-parity and an odd-parity instance,
// randomized words checked against a bit-counting reference model.
module tb_parity_frame_ctrl;
    localparam int WIDTH = 8;
    localparam int OW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parity_frame_ctrl_if #(.WIDTH(WIDTH)) bus0 ();
    parity_frame_ctrl_if #(.WIDTH(WIDTH)) bus1 ();

    parity_frame_ctrl #(.WIDTH(WIDTH), .ODD(0)) dut0 (.i_clk(clk), .i_rst(rst), .io_bus(bus0));
    parity_frame_ctrl #(.WIDTH(WIDTH), .ODD(1)) dut1 (.i_clk(clk), .i_rst(rst), .io_bus(bus1));

    typedef struct packed {
        logic          in_ready;
        logic          ser_clr;
        logic          ser_en;
        logic          ser_x;
        logic          out_valid;
        logic          parity_out;
        logic [OW-1:0] ones_cnt;
        logic          busy;
    } obs_t;

    // Reference model: count the ones, parity is the count's LSB flipped by the sense.
    function automatic int model_ones(input logic [WIDTH-1:0] d);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(d[i]);
        return n;
    endfunction

    function automatic logic model_par(input logic [WIDTH-1:0] d, input int odd);
        return 1'((model_ones(d) % 2 + odd) % 2);
    endfunction

    function automatic obs_t peek(input int inst);
        obs_t o;
        if (inst == 0) begin
            o = '{bus0.in_ready, bus0.ser_clr, bus0.ser_en, bus0.ser_x, bus0.out_valid,
                  bus0.parity_out, bus0.ones_cnt, bus0.busy};
        end else begin
            o = '{bus1.in_ready, bus1.ser_clr, bus1.ser_en, bus1.ser_x, bus1.out_valid,
                  bus1.parity_out, bus1.ones_cnt, bus1.busy};
        end
        return o;
    endfunction

    task automatic drive(input int inst, input logic v, input logic [WIDTH-1:0] d, input logic ordy);
        if (inst == 0) begin
            bus0.in_valid = v; bus0.in_data = d; bus0.out_ready = ordy;
        end else begin
            bus1.in_valid = v; bus1.in_data = d; bus1.out_ready = ordy;
        end
    endtask

    // Sends one word, records the serial stream and the result, then takes the result after bp cycles.
    task automatic xfer(input int inst, input logic [WIDTH-1:0] d, input int bp,
                        output logic [WIDTH-1:0] bits, output int n_en, output int n_clr,
                        output bit clr_first, output int lat, output logic par,
                        output logic [OW-1:0] ones);
        obs_t o;
        int   guard = 0;
        bits = '0; n_en = 0; n_clr = 0; clr_first = 1'b0; lat = -1; par = 1'b0; ones = '0;
        drive(inst, 1'b1, d, 1'b0);
        o = peek(inst);
        while (!o.in_ready && guard < 50) begin
            @(negedge clk);
            o = peek(inst);
            guard++;
        end
        @(negedge clk);
        drive(inst, 1'b0, '0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            o = peek(inst);
            if (o.ser_en) begin
                if (n_en < WIDTH) bits[n_en] = o.ser_x;
                if (o.ser_clr && n_en == 0) clr_first = 1'b1;
                n_en++;
            end
            if (o.ser_clr) n_clr++;
            if (o.out_valid) begin
                lat = k; par = o.parity_out; ones = o.ones_cnt;
                break;
            end
            @(negedge clk);
        end
        repeat (bp) @(negedge clk);
        drive(inst, 1'b0, '0, 1'b1);
        @(negedge clk);
        drive(inst, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        obs_t exp_o;
        obs_t o;
        exp_o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {OW{1'b0}}, 1'b0};
        rst = 1'b1;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        for (int inst = 0; inst < 2; inst++) begin
            o = peek(inst);
            checks++;
            if (o !== exp_o) begin
                errors++;
                $display("FAIL reset_values inst%0d: got %b want %b", inst, o, exp_o);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] bits, d;
        logic [OW-1:0]    ones;
        logic             par;
        int               n_en, n_clr, lat;
        bit               clr_first;
        for (int w = 0; w < 13; w++) begin
            d = (w == 0) ? 8'hA5 : 8'($urandom);
            xfer(0, d, 0, bits, n_en, n_clr, clr_first, lat, par, ones);
            checks++;
            if (bits !== d || n_en != WIDTH) begin
                errors++;
                $display("FAIL basic_serial d=%h: got bits %h n_en %0d want bits %h n_en %0d", d, bits, n_en, d, WIDTH);
            end
            checks++;
            if (n_clr != 1 || !clr_first) begin
                errors++;
                $display("FAIL basic_clr d=%h: got n_clr %0d first %0d want 1 1", d, n_clr, clr_first);
            end
            checks++;
            if (lat != WIDTH + 1) begin
                errors++;
                $display("FAIL basic_latency d=%h: got %0d want %0d", d, lat, WIDTH + 1);
            end
            checks++;
            if (par !== model_par(d, 0) || int'(ones) != model_ones(d)) begin
                errors++;
                $display("FAIL basic_result d=%h: got par %b ones %0d want par %b ones %0d",
                         d, par, ones, model_par(d, 0), model_ones(d));
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t          o;
        int            acc_cyc[$];
        logic          rp[$];
        logic [OW-1:0] ro[$];
        drive(0, 1'b1, 8'h07, 1'b1);
        for (int c = 0; c < 40 && ro.size() < 2; c++) begin
            o = peek(0);
            if (o.out_valid) begin
                rp.push_back(o.parity_out);
                ro.push_back(o.ones_cnt);
            end
            if (o.in_ready && bus0.in_valid) acc_cyc.push_back(c);
            @(negedge clk);
            if (acc_cyc.size() == 1) bus0.in_data = 8'hFF;
            else if (acc_cyc.size() >= 2) bus0.in_valid = 1'b0;
        end
        drive(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != WIDTH + 2) begin
            errors++;
            $display("FAIL b2b_period: got %0d accepts gap %0d want 2 accepts gap %0d",
                     acc_cyc.size(), (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1, WIDTH + 2);
        end
        checks++;
        if (ro.size() != 2 || rp[0] !== model_par(8'h07, 0) || int'(ro[0]) != model_ones(8'h07)
            || rp[1] !== model_par(8'hFF, 0) || int'(ro[1]) != model_ones(8'hFF)) begin
            errors++;
            $display("FAIL b2b_results: got %0d results first %b/%0d want par %b ones %0d then %b/%0d",
                     ro.size(), (rp.size() > 0) ? rp[0] : 1'bx, (ro.size() > 0) ? ro[0] : '0,
                     model_par(8'h07, 0), model_ones(8'h07), model_par(8'hFF, 0), model_ones(8'hFF));
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        obs_t exp_o;
        int   guard = 0;
        drive(0, 1'b1, 8'h01, 1'b0);
        o = peek(0);
        while (!o.in_ready && guard < 30) begin @(negedge clk); o = peek(0); guard++; end
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        o = peek(0);
        guard = 0;
        while (!o.out_valid && guard < 30) begin @(negedge clk); o = peek(0); guard++; end
        exp_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_par(8'h01, 0), OW'(model_ones(8'h01)), 1'b1};
        for (int i = 0; i < 5; i++) begin
            o = peek(0);
            checks++;
            if (o !== exp_o) begin
                errors++;
                $display("FAIL bp_hold cycle%0d: got %b want %b", i, o, exp_o);
            end
            @(negedge clk);
        end
        drive(0, 1'b0, '0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        o = peek(0);
        exp_o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, model_par(8'h01, 0), OW'(model_ones(8'h01)), 1'b0};
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("FAIL bp_release: got %b want %b", o, exp_o);
        end
    endtask

    task automatic test_odd();
        logic [WIDTH-1:0] bits, d;
        logic [OW-1:0]    ones;
        logic             par;
        int               n_en, n_clr, lat;
        bit               clr_first;
        for (int w = 0; w < 5; w++) begin
            d = (w == 0) ? 8'h00 : (w == 1) ? 8'h80 : 8'($urandom);
            xfer(1, d, w, bits, n_en, n_clr, clr_first, lat, par, ones);
            checks++;
            if (par !== model_par(d, 1) || int'(ones) != model_ones(d) || lat != WIDTH + 1) begin
                errors++;
                $display("FAIL odd_result d=%h: got par %b ones %0d lat %0d want par %b ones %0d lat %0d",
                         d, par, ones, lat, model_par(d, 1), model_ones(d), WIDTH + 1);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        obs_t             o;
        obs_t             exp_o;
        logic [WIDTH-1:0] bits;
        logic [OW-1:0]    ones;
        logic             par;
        int               n_en, n_clr, lat, guard, n_seen, n_ov;
        bit               clr_first;
        drive(0, 1'b1, 8'hA5, 1'b0);
        guard = 0;
        o = peek(0);
        while (!o.in_ready && guard < 30) begin @(negedge clk); o = peek(0); guard++; end
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        n_seen = 0;
        for (int c = 0; c < 20; c++) begin
            o = peek(0);
            if (o.ser_en) n_seen++;
            if (n_seen == 3) break;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = peek(0);
        exp_o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {OW{1'b0}}, 1'b0};
        checks++;
        if (n_seen != 3 || o !== exp_o) begin
            errors++;
            $display("FAIL midrst_values: got %b (ser_en seen %0d) want %b (3)", o, n_seen, exp_o);
        end
        n_ov = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            o = peek(0);
            if (o.out_valid) n_ov++;
        end
        checks++;
        if (n_ov != 0) begin
            errors++;
            $display("FAIL midrst_no_result: got %0d out_valid cycles want 0", n_ov);
        end
        xfer(0, 8'h03, 0, bits, n_en, n_clr, clr_first, lat, par, ones);
        checks++;
        if (par !== model_par(8'h03, 0) || int'(ones) != model_ones(8'h03)) begin
            errors++;
            $display("FAIL midrst_next_word: got par %b ones %0d want par %b ones %0d",
                     par, ones, model_par(8'h03, 0), model_ones(8'h03));
        end
    endtask

    task automatic test_ignored_input();
        obs_t          o;
        int            n_acc = 0, n_res = 0, dwell = 0;
        logic          rpar = 1'bx;
        logic [OW-1:0] rones = '0;
        drive(0, 1'b1, 8'h3C, 1'b0);
        for (int c = 0; c < 60; c++) begin
            o = peek(0);
            if (o.in_ready && bus0.in_valid) n_acc++;
            if (o.out_valid && bus0.out_ready) begin
                n_res++; rpar = o.parity_out; rones = o.ones_cnt;
                break;
            end
            @(negedge clk);
            o = peek(0);
            if (o.out_valid) dwell++;
            if (o.out_valid && dwell > 3) begin
                bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
            end else if (n_acc > 0) begin
                bus0.in_valid  = 1'($urandom_range(0, 1));
                bus0.in_data   = 8'($urandom);
                bus0.out_ready = 1'b0;
            end else begin
                bus0.out_ready = 1'b0;
            end
        end
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        checks++;
        if (n_acc != 1 || n_res != 1) begin
            errors++;
            $display("FAIL ignored_accepts: got %0d accepts %0d results want 1 1", n_acc, n_res);
        end
        checks++;
        if (rpar !== model_par(8'h3C, 0) || int'(rones) != model_ones(8'h3C)) begin
            errors++;
            $display("FAIL ignored_result: got par %b ones %0d want par %b ones %0d",
                     rpar, rones, model_par(8'h3C, 0), model_ones(8'h3C));
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_odd();
        test_reset_mid_shift();
        test_ignored_input();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/parity_frame_ctrl.md
Name: parity_frame_ctrl

Overview:
- Word-level controller that sequences a serial odd/even parity datapath.
- Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first, one bit per clock, on a serial strobe interface that feeds the bit-serial parity FSM.
- Tracks parity and ones-count internally, then presents a per-word result over a second valid/ready handshake.
- Sits between a word producer and the serial parity checker. It frames the checker's bit stream into words.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- ODD, 0, parity sense: 0 -> parity_out = XOR of bits (even-parity bit); 1 -> parity_out = inverted XOR (odd-parity bit).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  parallel word.
- ser_clr  output  1  one-cycle pulse: start of a new serial frame.
- ser_en  output  1  ser_x carries a valid data bit this cycle.
- ser_x  output  1  serial data bit, LSB first.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts the result.
- parity_out  output  1  parity of the last word, per ODD.
- ones_cnt  output  $clog2(WIDTH+1)  number of 1 bits in the last word.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; shreg, bit counter, parity accumulator and ones counter cleared to 0; in_ready=1, out_valid=0, ser_en=0, ser_x=0, ser_clr=0, parity_out=0, ones_cnt=0, busy=0.
- Reset mid-operation: rst asserted during SHIFT or DONE aborts the word. The next cycle shows reset values, with no out_valid pulse for the aborted word.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch in_data into shreg; clear acc, cnt and ones; pulse ser_clr=1 for the following cycle; go to SHIFT.
- SHIFT:
  - in_ready=0, ser_en=1, ser_x=shreg[0].
  - Each edge: acc <= acc ^ shreg[0]; ones <= ones + shreg[0]; shreg shifts right by 1 with zero fill; cnt++.
  - When cnt reaches WIDTH-1 at an edge, go to DONE. Exactly WIDTH ser_en cycles per word.
- DONE:
  - out_valid=1, parity_out=acc ^ ODD, ones_cnt=ones. Values are stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE (no bypass).
- Latency: word accepted at edge E0. ser_en is high for cycles E0+1 .. E0+WIDTH. out_valid is first high at E0+WIDTH+1. Minimum word period is WIDTH+2 cycles.
- ser_clr coincides with the first ser_en cycle, so the downstream checker restarts on the first bit.
- parity_out and ones_cnt hold the last result after leaving DONE, until the next DONE. out_valid is 0 outside DONE.
- in_valid outside IDLE is ignored; in_data is not sampled.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes. The word is accepted at the earliest on the next edge, in IDLE.
- Widths: ones counter is $clog2(WIDTH+1) bits and never overflows (max WIDTH). Bit counter is $clog2(WIDTH) bits.

Test Plan:
- WIDTH=8, ODD=0: send 0xA5, out_ready=1.
  - ser_x over 8 ser_en cycles = 1,0,1,0,0,1,0,1.
  - ser_clr high only on the first of them.
  - out_valid at E0+9 with parity_out=0, ones_cnt=4.
- Send 0x07 then 0xFF back-to-back, in_valid held.
  - Results: (parity 1, ones 3) then (parity 0, ones 8).
  - Second accept occurs exactly 10 cycles after the first.
- Backpressure: send 0x01 with out_ready=0 for 5 cycles after out_valid.
  - out_valid, parity_out=1 and ones_cnt=1 stay stable; in_ready stays 0.
  - Return to IDLE one edge after out_ready=1.
- ODD=1 instance: 0x00 -> parity_out=1, ones_cnt=0; 0x80 -> parity_out=0, ones_cnt=1.
- Reset mid-SHIFT: accept 0xA5, assert rst on the 3rd ser_en cycle.
  - Next cycle shows all reset values; no out_valid appears.
  - A following 0x03 yields parity 0, ones 2.
- Ignored input: toggle in_valid/in_data randomly during SHIFT and DONE of 0x3C.
  - Result is parity 0, ones 4.
  - No extra accepts: exactly one accept per result.
